fp_round64_pipe: RTL and testbench
==================================

FP_ROUND64_PIPE -- requirements
Module: fp_round64_pipe

Interface
REQ-001 SHALL have parameter TAGW, default 4, width of the pass-through transaction tag.
REQ-002 SHALL have parameter QUIET_NAN, default 1; when 1, the NaN output quiet bit (o[51]) is forced to 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 valid_i  input  1  upstream (normalizer output) data valid.
REQ-006 ready_o  output  1  block can accept an input this cycle.
REQ-007 rm_i  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward -inf), 3 RUP (toward +inf), 4 RMM (nearest, ties away); 5-7 treated as RNE.
REQ-008 sign_i  input  1  sign.
REQ-009 exp_i  input  11  biased exponent; 0 = denormal/zero, 0x7FF = Inf/NaN.
REQ-010 sig_i  input  55  [54] whole bit, [53:2] 52-bit fraction, [1] guard, [0] sticky.
REQ-011 under_i  input  1  normalizer underflow indication.
REQ-012 inexact_i  input  1  precision already lost upstream.
REQ-013 tag_i  input  TAGW  opaque tag, returned with the result.
REQ-014 valid_o  output  1  result valid.
REQ-015 ready_i  input  1  downstream accepts the result.
REQ-016 o  output  64  IEEE-754 binary64 result.
REQ-017 tag_o  output  TAGW  tag of the result.
REQ-018 inexact_o, overflow_o, underflow_o  output  1 each  exception flags aligned with o.

Function
REQ-019 SHALL be a 2-stage pipeline (S1 decision, S2 add/pack); latency is exactly 2 cycles from accept to valid_o when not stalled.
REQ-020 Transfers: input accepted when valid_i & ready_o; output consumed when valid_o & ready_i.
REQ-021 en2 = !v2 | ready_i; en1 = !v1 | en2; ready_o = en1 (combinational from ready_i and stage-valid flags); throughput 1 per cycle.
REQ-022 While valid_o & !ready_i, o, tag_o, flags and valid_o SHALL remain stable; no result is dropped or duplicated, and order is preserved.
REQ-023 S1 SHALL register inputs and compute inc from lsb=sig_i[2], g=sig_i[1], s=sig_i[0]: RNE g&(s|lsb); RTZ 0; RDN sign&(g|s); RUP !sign&(g|s); RMM g.
REQ-024 exp_i==0x7FF (Inf/NaN): inc SHALL be 0; output {sign, 0x7FF, fraction}; if fraction!=0 and QUIET_NAN=1, o[51]=1; all flags 0.
REQ-025 S2 SHALL form the 63-bit value {exp, fraction} + inc, so that a fraction carry increments the exponent (this also covers denormal-to-normal at exp 0).
REQ-026 If the S2 sum reaches exponent 0x7FF (finite input only), o SHALL be {sign, 0x7FF, 52'b0} and overflow_o=1.
REQ-027 Finite input: inexact_o = g | s | inexact_i, or 1 when overflow_o=1.
REQ-028 Finite input: underflow_o = under_i & inexact_o.
REQ-029 Zero input (exp 0, sig 0): output ±0 with sign preserved and all flags 0.
REQ-030 tag_i SHALL travel with its data through both stages unchanged.

Reset
REQ-031 On rst asserted, v1, v2, valid_o, o, tag_o and all flags SHALL clear to 0 immediately, without waiting for clk.
REQ-032 Reset mid-operation SHALL discard in-flight data; ready_o=1 on the first cycle after rst deasserts.

Verification
REQ-033 RNE tie-even: sign 0, exp 0x3FF, sig whole 1, frac 0, g=1, s=0 -> o=0x3FF0000000000000, inexact_o=1, 2 cycles later.
REQ-034 RNE tie-odd: same as REQ-033 but frac=1 -> o=0x3FF0000000000002; same input with rm=RTZ -> 0x3FF0000000000001.
REQ-035 Carry: exp 0x3FF, frac all ones, g=1, rm RNE -> o=0x4000000000000000; exp 0x7FE, frac all ones, g=1, rm RUP, sign 0 -> o=0x7FF0000000000000, overflow_o=1, inexact_o=1.
REQ-036 Denormal: exp 0, frac 0xFFFFFFFFFFFFF, g=1, under_i=1, rm RNE -> o=0x0010000000000000, underflow_o=1; signalling NaN 0x7FF0000000000001 -> 0x7FF8000000000001, no flags.
REQ-037 Backpressure: ready_i=0 while tags 1,2,3 are offered back to back -> tags 1 and 2 accepted, ready_o=0 while tag 3 is offered, valid_o stays high with tag 1 stable; after ready_i=1, tags 1,2,3 emerge in order, each exactly once.
REQ-038 Reset while two items are in flight -> valid_o drops to 0 asynchronously, no stale output after release.

Source files
------------

// File: rtl/fp_round64_if.sv
// Handshake and data bundle between the normalizer, the rounder and the downstream consumer.
// The slave modport is the rounder's view; the master modport is the view of whoever drives it.
interface fp_round64_if #(
  parameter int unsigned TAGW = 4
) ();
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      rm_i;
  logic            sign_i;
  logic [10:0]     exp_i;
  logic [54:0]     sig_i;
  logic            under_i;
  logic            inexact_i;
  logic [TAGW-1:0] tag_i;
  logic            valid_o;
  logic            ready_i;
  logic [63:0]     o;
  logic [TAGW-1:0] tag_o;
  logic            inexact_o;
  logic            overflow_o;
  logic            underflow_o;

  modport slave (
    input  valid_i, rm_i, sign_i, exp_i, sig_i, under_i, inexact_i, tag_i, ready_i,
    output ready_o, valid_o, o, tag_o, inexact_o, overflow_o, underflow_o
  );

  modport master (
    output valid_i, rm_i, sign_i, exp_i, sig_i, under_i, inexact_i, tag_i, ready_i,
    input  ready_o, valid_o, o, tag_o, inexact_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fp_round64_pipe.sv
// Two-stage binary64 rounder: stage 1 registers the operand and decides the increment,
// stage 2 adds it into {exp, fraction}, packs the result and derives the exception flags.
module fp_round64_pipe #(
  parameter int unsigned TAGW      = 4,
  parameter bit          QUIET_NAN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  fp_round64_if.slave  bus
);

  localparam logic [10:0] ExpMax = 11'h7FF;
  localparam logic [2:0]  RmRtz  = 3'd1;
  localparam logic [2:0]  RmRdn  = 3'd2;
  localparam logic [2:0]  RmRup  = 3'd3;
  localparam logic [2:0]  RmRmm  = 3'd4;

  logic en1, en2;
  logic v1_q, v2_q;

  assign en2         = !v2_q | bus.ready_i;
  assign en1         = !v1_q | en2;
  assign bus.ready_o = en1;

  // Stage 1: rounding decision
  logic lsb, g, s, inc_d, special_d, zero_d;

  always_comb begin
    lsb       = bus.sig_i[2];
    g         = bus.sig_i[1];
    s         = bus.sig_i[0];
    special_d = (bus.exp_i == ExpMax);
    zero_d    = (bus.exp_i == 11'd0) && (bus.sig_i == 55'd0);
    inc_d     = 1'b0;
    case (bus.rm_i)
      RmRtz:   inc_d = 1'b0;
      RmRdn:   inc_d = bus.sign_i & (g | s);
      RmRup:   inc_d = !bus.sign_i & (g | s);
      RmRmm:   inc_d = g;
      default: inc_d = g & (s | lsb);
    endcase
    if (special_d) inc_d = 1'b0;
  end

  logic            sign_q, inc_q, gs_q, under_q, inx_q, special_q, zero_q;
  logic [10:0]     exp_q;
  logic [51:0]     frac_q;
  logic [TAGW-1:0] tag1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      inc_q     <= 1'b0;
      gs_q      <= 1'b0;
      under_q   <= 1'b0;
      inx_q     <= 1'b0;
      special_q <= 1'b0;
      zero_q    <= 1'b0;
      tag1_q    <= '0;
    end else if (en1) begin
      v1_q      <= bus.valid_i;
      sign_q    <= bus.sign_i;
      exp_q     <= bus.exp_i;
      frac_q    <= bus.sig_i[53:2];
      inc_q     <= inc_d;
      gs_q      <= bus.sig_i[1] | bus.sig_i[0];
      under_q   <= bus.under_i;
      inx_q     <= bus.inexact_i;
      special_q <= special_d;
      zero_q    <= zero_d;
      tag1_q    <= bus.tag_i;
    end
  end

  // Stage 2: a fraction carry ripples into the exponent, which also promotes denormals
  logic [62:0] sum;
  logic [51:0] nan_frac;
  logic [63:0] o_d;
  logic        inx_d, ovf_d, unf_d;

  assign sum = {exp_q, frac_q} + 63'(inc_q);

  always_comb begin
    o_d      = {sign_q, sum};
    inx_d    = gs_q | inx_q;
    ovf_d    = 1'b0;
    nan_frac = frac_q;
    if (special_q) begin
      if (QUIET_NAN && (frac_q != 52'd0)) nan_frac[51] = 1'b1;
      o_d   = {sign_q, ExpMax, nan_frac};
      inx_d = 1'b0;
    end else if (zero_q) begin
      o_d   = {sign_q, 63'd0};
      inx_d = 1'b0;
    end else if (sum[62:52] == ExpMax) begin
      o_d   = {sign_q, ExpMax, 52'd0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
    unf_d = under_q & inx_d;
  end

  logic [63:0]     o_q;
  logic [TAGW-1:0] tag2_q;
  logic            inx2_q, ovf2_q, unf2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      o_q    <= '0;
      tag2_q <= '0;
      inx2_q <= 1'b0;
      ovf2_q <= 1'b0;
      unf2_q <= 1'b0;
    end else if (en2) begin
      v2_q   <= v1_q;
      o_q    <= o_d;
      tag2_q <= tag1_q;
      inx2_q <= inx_d;
      ovf2_q <= ovf_d;
      unf2_q <= unf_d;
    end
  end

  assign bus.valid_o     = v2_q;
  assign bus.o           = o_q;
  assign bus.tag_o       = tag2_q;
  assign bus.inexact_o   = inx2_q;
  assign bus.overflow_o  = ovf2_q;
  assign bus.underflow_o = unf2_q;

endmodule

// File: tb/tb_fp_round64_pipe.sv
// Bench for fp_round64_pipe: directed corner cases, backpressure and reset checks, plus a
// randomized run scored against a value-level rounding model.
module tb_fp_round64_pipe;

  localparam int unsigned TAGW      = 4;
  localparam bit          QUIET_NAN = 1'b1;

  logic clk;
  logic rst;

  fp_round64_if #(.TAGW(TAGW)) bus ();

  fp_round64_pipe #(.TAGW(TAGW), .QUIET_NAN(QUIET_NAN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]     o;
    logic [TAGW-1:0] tag;
    logic            inx;
    logic            ovf;
    logic            unf;
  } res_t;

  res_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Rounding by value: the discarded part {g,s} is below, at, or above half an ulp.
  function automatic res_t model(input logic [2:0] rm, input logic sign, input logic [10:0] e,
                                 input logic [54:0] sig, input logic under, input logic inx_in,
                                 input logic [TAGW-1:0] tag);
    res_t            r;
    logic [51:0]     frac;
    int unsigned     rem;
    bit              up;
    longint unsigned mag;
    r     = '0;
    r.tag = tag;
    frac  = sig[53:2];
    rem   = {30'd0, sig[1:0]};
    if (e == 11'h7FF) begin
      if (frac != 52'd0 && QUIET_NAN) frac[51] = 1'b1;
      r.o = {sign, e, frac};
      return r;
    end
    if (e == 11'd0 && sig == 55'd0) begin
      r.o = {sign, 63'd0};
      return r;
    end
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sign && rem != 0;
      3'd3:    up = !sign && rem != 0;
      3'd4:    up = rem >= 2;
      default: up = rem > 2 || (rem == 2 && sig[2]);
    endcase
    mag   = 64'({e, frac}) + 64'(up);
    r.inx = rem != 0 || inx_in;
    if (mag >= 64'h7FF0_0000_0000_0000) begin
      r.ovf = 1'b1;
      r.inx = 1'b1;
      r.o   = {sign, 11'h7FF, 52'd0};
    end else begin
      r.o = {sign, mag[62:0]};
    end
    r.unf = under && r.inx;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          check("sb_extra", 64'(sb.size()), 64'd1);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("res_o", bus.o, e.o);
          check("res_tag", 64'(bus.tag_o), 64'(e.tag));
          check("res_flg", 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}),
                64'({e.inx, e.ovf, e.unf}));
          n_out++;
        end
      end
      if (bus.valid_i && bus.ready_o)
        sb.push_back(model(bus.rm_i, bus.sign_i, bus.exp_i, bus.sig_i, bus.under_i,
                           bus.inexact_i, bus.tag_i));
    end
  end

  task automatic send(input logic [2:0] rm, input logic sg, input logic [10:0] e,
                      input logic [54:0] sig, input logic un, input logic ix,
                      input logic [TAGW-1:0] tg);
    bit acc;
    int n;
    bus.valid_i   = 1'b1;
    bus.rm_i      = rm;
    bus.sign_i    = sg;
    bus.exp_i     = e;
    bus.sig_i     = sig;
    bus.under_i   = un;
    bus.inexact_i = ix;
    bus.tag_i     = tg;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_acc", 64'(acc), 64'd1);
    bus.valid_i = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [2:0] rm, input logic sg,
                         input logic [10:0] e, input logic [54:0] sig, input logic un,
                         input logic [63:0] want_o, input logic [2:0] want_f);
    int cyc;
    bus.ready_i = 1'b1;
    send(rm, sg, e, sig, un, 1'b0, 4'hA);
    cyc = 1;
    while (!bus.valid_o && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_lat"}, 64'(cyc), 64'd2);
    check(name, bus.o, want_o);
    check({name, "_flg"}, 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}), 64'(want_f));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b0;
    bus.rm_i      = '0;
    bus.sign_i    = 1'b0;
    bus.exp_i     = '0;
    bus.sig_i     = '0;
    bus.under_i   = 1'b0;
    bus.inexact_i = 1'b0;
    bus.tag_i     = '0;
    #3;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_o", bus.o, 64'd0);
    check("rst_tag", 64'(bus.tag_o), 64'd0);
    check("rst_flg", 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases: {inexact, overflow, underflow}
    run_one("tie_even", 3'd0, 1'b0, 11'h3FF, {1'b1, 52'h0, 2'b10}, 1'b0,
            64'h3FF0_0000_0000_0000, 3'b100);
    run_one("tie_odd", 3'd0, 1'b0, 11'h3FF, {1'b1, 52'h1, 2'b10}, 1'b0,
            64'h3FF0_0000_0000_0002, 3'b100);
    run_one("rtz", 3'd1, 1'b0, 11'h3FF, {1'b1, 52'h1, 2'b10}, 1'b0,
            64'h3FF0_0000_0000_0001, 3'b100);
    run_one("carry", 3'd0, 1'b0, 11'h3FF, {1'b1, {52{1'b1}}, 2'b10}, 1'b0,
            64'h4000_0000_0000_0000, 3'b100);
    run_one("ovf", 3'd3, 1'b0, 11'h7FE, {1'b1, {52{1'b1}}, 2'b10}, 1'b0,
            64'h7FF0_0000_0000_0000, 3'b110);
    run_one("denorm", 3'd0, 1'b0, 11'h000, {1'b0, {52{1'b1}}, 2'b10}, 1'b1,
            64'h0010_0000_0000_0000, 3'b101);
    run_one("snan", 3'd0, 1'b0, 11'h7FF, {1'b1, 52'h1, 2'b00}, 1'b0,
            64'h7FF8_0000_0000_0001, 3'b000);
    run_one("inf", 3'd3, 1'b1, 11'h7FF, {1'b1, 52'h0, 2'b11}, 1'b0,
            64'hFFF0_0000_0000_0000, 3'b000);
    run_one("negzero", 3'd2, 1'b1, 11'h000, 55'd0, 1'b0,
            64'h8000_0000_0000_0000, 3'b000);
    run_one("rdn_neg", 3'd2, 1'b1, 11'h3FF, {1'b1, 52'h0, 2'b01}, 1'b0,
            64'hBFF0_0000_0000_0001, 3'b100);
    run_one("rmm_tie", 3'd4, 1'b0, 11'h3FF, {1'b1, 52'h0, 2'b10}, 1'b0,
            64'h3FF0_0000_0000_0001, 3'b100);
    run_one("rm7_rne", 3'd7, 1'b0, 11'h3FF, {1'b1, 52'h0, 2'b10}, 1'b0,
            64'h3FF0_0000_0000_0000, 3'b100);

    // Backpressure: tags 1,2 fill the pipe, 3 must wait
    bus.ready_i = 1'b0;
    n0 = n_out;
    bus.valid_i = 1'b1;
    bus.rm_i    = 3'd0;
    bus.exp_i   = 11'h400;
    bus.sig_i   = {1'b1, 52'h12345, 2'b11};
    bus.tag_i   = 4'd1;
    @(posedge clk);
    #1;
    bus.tag_i = 4'd2;
    @(posedge clk);
    #1;
    bus.tag_i = 4'd3;
    check("bp_ready", 64'(bus.ready_o), 64'd0);
    check("bp_valid", 64'(bus.valid_o), 64'd1);
    check("bp_tag", 64'(bus.tag_o), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", 64'(bus.valid_o), 64'd1);
    check("bp_hold_tag", 64'(bus.tag_o), 64'd1);
    check("bp_hold_ready", 64'(bus.ready_o), 64'd0);
    bus.ready_i = 1'b1;
    #1;
    check("bp_release", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", 64'(n_out - n0), 64'd3);
    check("bp_drain", 64'(sb.size()), 64'd0);

    // Reset with two items in flight
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.tag_i   = 4'd5;
    @(posedge clk);
    #1;
    bus.tag_i = 4'd6;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check("inflight_valid", 64'(bus.valid_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_valid", 64'(bus.valid_o), 64'd0);
    check("async_o", bus.o, 64'd0);
    check("async_tag", 64'(bus.tag_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.ready_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_stale", 64'(bus.valid_o), 64'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.rm_i    = 3'($urandom_range(0, 7));
      bus.sign_i  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       bus.exp_i = 11'h000;
        1:       bus.exp_i = 11'h7FF;
        2:       bus.exp_i = 11'h7FE;
        default: bus.exp_i = 11'($urandom_range(0, 2046));
      endcase
      bus.sig_i = 55'({$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) bus.sig_i[53:2] = '1;
      if ($urandom_range(0, 9) == 0) bus.sig_i = '0;
      bus.under_i   = 1'($urandom_range(0, 1));
      bus.inexact_i = ($urandom_range(0, 5) == 0);
      bus.tag_i     = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rand_drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
